multi_channel_sync_fifo: RTL and testbench

// Parametrised successor to the single-queue simulator FIFO: NUM_CHANNELS independent FIFO queues in one

---
 rtl/multi_channel_sync_fifo.sv | 136 +++++++++++++
 tb/tb_multi_channel_sync_fifo.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/multi_channel_sync_fifo.sv
// NUM_CHANNELS independent show-ahead FIFOs sharing one enqueue and one dequeue port.
// Optional sticky per-channel error flags: define MULTI_CHANNEL_FIFO_ERROR_CHECK_EN.
module multi_channel_sync_fifo #(
  parameter int WIDTH                  = 32,
  parameter int SIZE                   = 8,
  parameter int NUM_CHANNELS           = 4,
  parameter int ALMOST_FULL_THRESHOLD  = SIZE,
  parameter int ALMOST_EMPTY_THRESHOLD = 1,
  localparam int CHANNEL_IDX_WIDTH     = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
  localparam int COUNT_WIDTH           = $clog2(SIZE + 1)
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic [NUM_CHANNELS-1:0]             flush_en,
  input  logic                                enqueue_en,
  input  logic [CHANNEL_IDX_WIDTH-1:0]        enqueue_channel,
  input  logic [WIDTH-1:0]                    enqueue_value,
  input  logic                                dequeue_en,
  input  logic [CHANNEL_IDX_WIDTH-1:0]        dequeue_channel,
  output logic [WIDTH-1:0]                    dequeue_value,
  output logic [NUM_CHANNELS-1:0]             full,
  output logic [NUM_CHANNELS-1:0]             almost_full,
  output logic [NUM_CHANNELS-1:0]             empty,
  output logic [NUM_CHANNELS-1:0]             almost_empty,
  output logic [NUM_CHANNELS*COUNT_WIDTH-1:0] count,
  output logic [NUM_CHANNELS-1:0]             error
);

  localparam int PTR_WIDTH = $clog2(SIZE);
  localparam logic [COUNT_WIDTH-1:0] FULL_CNT = COUNT_WIDTH'(SIZE);
  localparam logic [COUNT_WIDTH-1:0] AF_CNT   = COUNT_WIDTH'(ALMOST_FULL_THRESHOLD);
  localparam logic [COUNT_WIDTH-1:0] AE_CNT   = COUNT_WIDTH'(ALMOST_EMPTY_THRESHOLD);

  logic [WIDTH-1:0]       mem  [NUM_CHANNELS][SIZE];
  logic [PTR_WIDTH-1:0]   head [NUM_CHANNELS];
  logic [PTR_WIDTH-1:0]   tail [NUM_CHANNELS];
  logic [COUNT_WIDTH-1:0] cnt  [NUM_CHANNELS];

  logic [NUM_CHANNELS-1:0] enq_sel, deq_sel, enq_ok, deq_ok;

  // A full channel may accept a write only when its head is popped on the same edge.
  always_comb begin
    enq_sel = '0;
    deq_sel = '0;
    enq_ok  = '0;
    deq_ok  = '0;
    for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
      enq_sel[c] = enqueue_en && (enqueue_channel == CHANNEL_IDX_WIDTH'(c));
      deq_sel[c] = dequeue_en && (dequeue_channel == CHANNEL_IDX_WIDTH'(c));
      deq_ok[c]  = deq_sel[c] && !flush_en[c] && (cnt[c] != '0);
      enq_ok[c]  = enq_sel[c] && !flush_en[c] && ((cnt[c] != FULL_CNT) || deq_ok[c]);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
        head[c] <= '0;
        tail[c] <= '0;
        cnt[c]  <= '0;
      end
    end else begin
      for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
        if (flush_en[c]) begin
          head[c] <= '0;
          tail[c] <= '0;
          cnt[c]  <= '0;
        end else begin
          if (enq_ok[c]) tail[c] <= tail[c] + PTR_WIDTH'(1);
          if (deq_ok[c]) head[c] <= head[c] + PTR_WIDTH'(1);
          if (enq_ok[c] && !deq_ok[c])      cnt[c] <= cnt[c] + COUNT_WIDTH'(1);
          else if (!enq_ok[c] && deq_ok[c]) cnt[c] <= cnt[c] - COUNT_WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
      if (enq_ok[c]) mem[c][tail[c]] <= enqueue_value;
    end
  end

  always_comb begin
    dequeue_value = '0;
    full          = '0;
    almost_full   = '0;
    empty         = '0;
    almost_empty  = '0;
    count         = '0;
    for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
      full[c]         = (cnt[c] == FULL_CNT);
      almost_full[c]  = (cnt[c] >= AF_CNT);
      empty[c]        = (cnt[c] == '0);
      almost_empty[c] = (cnt[c] <= AE_CNT);
      count[c*COUNT_WIDTH +: COUNT_WIDTH] = cnt[c];
      if (dequeue_channel == CHANNEL_IDX_WIDTH'(c)) dequeue_value = mem[c][head[c]];
    end
  end

`ifdef MULTI_CHANNEL_FIFO_ERROR_CHECK_EN
  logic [NUM_CHANNELS-1:0] ovf, unf, err_q;

  always_comb begin
    ovf = '0;
    unf = '0;
    for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
      ovf[c] = enq_sel[c] && !flush_en[c] && !enq_ok[c];
      unf[c] = deq_sel[c] && !flush_en[c] && !deq_ok[c];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_q <= '0;
    end else begin
      for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
        if (flush_en[c])          err_q[c] <= 1'b0;
        else if (ovf[c] || unf[c]) err_q[c] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
      assert (!(reset_n && ovf[c])) else $error("channel %0d: enqueue while full", c);
      assert (!(reset_n && unf[c])) else $error("channel %0d: dequeue while empty", c);
    end
  end

  assign error = err_q;
`else
  assign error = '0;
`endif

endmodule

// File: tb/tb_multi_channel_sync_fifo.sv
// Scoreboard bench for multi_channel_sync_fifo: per-channel queue model, per-cycle expected records.
module tb_multi_channel_sync_fifo;

  localparam int W = 32;
  localparam int SZ = 8;
  localparam int NCH = 4;
`ifdef MULTI_CHANNEL_FIFO_ERROR_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset_n;
  logic [NCH-1:0]  flush_en;
  logic            enqueue_en;
  logic [1:0]      enqueue_channel;
  logic [W-1:0]    enqueue_value;
  logic            dequeue_en;
  logic [1:0]      dequeue_channel;
  logic [W-1:0]    dequeue_value;
  logic [NCH-1:0]  full, almost_full, empty, almost_empty, error;
  logic [NCH*4-1:0] count;

  multi_channel_sync_fifo #(.WIDTH(W), .SIZE(SZ), .NUM_CHANNELS(NCH)) dut (
    .clk(clk), .reset_n(reset_n), .flush_en(flush_en),
    .enqueue_en(enqueue_en), .enqueue_channel(enqueue_channel), .enqueue_value(enqueue_value),
    .dequeue_en(dequeue_en), .dequeue_channel(dequeue_channel), .dequeue_value(dequeue_value),
    .full(full), .almost_full(almost_full), .empty(empty), .almost_empty(almost_empty),
    .count(count), .error(error)
  );

  always #5 clk = ~clk;

  typedef logic [W-1:0] word_t;
  typedef struct {
    bit        dv;
    word_t     dval;
    logic [NCH-1:0]   emp, ful, ae, af, err;
    logic [NCH*4-1:0] cnt;
  } exp_t;

  word_t          mq [NCH][$];
  logic [NCH-1:0] merr;
  exp_t           exq [$];
  int             n_checks = 0;
  int             n_pass = 0;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // One bus cycle: record expectations for the pre-edge state, then advance the model.
  task automatic cycle(input logic [NCH-1:0] fl, input logic en, input logic [1:0] ec,
                       input word_t ev, input logic de, input logic [1:0] dc);
    exp_t r;
    bit d_ok, e_ok;
    flush_en = fl; enqueue_en = en; enqueue_channel = ec; enqueue_value = ev;
    dequeue_en = de; dequeue_channel = dc;
    r.dv = (mq[dc].size() > 0);
    r.dval = r.dv ? mq[dc][0] : '0;
    r.cnt = '0;
    for (int c = 0; c < NCH; c++) begin
      r.emp[c] = (mq[c].size() == 0);
      r.ful[c] = (mq[c].size() == SZ);
      r.ae[c]  = (mq[c].size() <= 1);
      r.af[c]  = (mq[c].size() >= SZ);
      r.cnt[c*4 +: 4] = 4'(mq[c].size());
    end
    r.err = ERR_EN ? merr : '0;
    exq.push_back(r);
    @(posedge clk); #1;
    for (int c = 0; c < NCH; c++) begin
      if (fl[c]) begin
        mq[c].delete();
        merr[c] = 1'b0;
      end else begin
        d_ok = de && (dc == c) && (mq[c].size() > 0);
        e_ok = en && (ec == c) && ((mq[c].size() < SZ) || d_ok);
        if (de && dc == c && !d_ok) merr[c] = 1'b1;
        if (en && ec == c && !e_ok) merr[c] = 1'b1;
        if (d_ok) void'(mq[c].pop_front());
        if (e_ok) mq[c].push_back(ev);
      end
    end
  endtask

  task automatic idle(input logic [1:0] dc);
    cycle('0, 1'b0, 2'd0, '0, 1'b0, dc);
  endtask

  initial begin
    exp_t r;
    forever begin
      @(negedge clk);
      if (exq.size() > 0) begin
        r = exq.pop_front();
        chk("count", W'(count), W'(r.cnt));
        chk("empty", W'(empty), W'(r.emp));
        chk("full", W'(full), W'(r.ful));
        chk("almost_empty", W'(almost_empty), W'(r.ae));
        chk("almost_full", W'(almost_full), W'(r.af));
        chk("error", W'(error), W'(r.err));
        if (r.dv) chk("dequeue_value", dequeue_value, r.dval);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    word_t v;
    reset_n = 1'b0;
    flush_en = '0; enqueue_en = 1'b0; enqueue_channel = '0; enqueue_value = '0;
    dequeue_en = 1'b0; dequeue_channel = '0;
    merr = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_empty", W'(empty), W'(4'hf));
    chk("reset_count", W'(count), '0);
    reset_n = 1'b1;
    repeat (2) idle(2'd0);

    // Fill ch1, one overflow attempt, drain, one underflow attempt.
    for (int i = 0; i < SZ + 1; i++) cycle('0, 1'b1, 2'd1, $urandom, 1'b0, 2'd1);
    for (int i = 0; i < SZ + 1; i++) cycle('0, 1'b0, 2'd0, '0, 1'b1, 2'd1);
    idle(2'd1);

    // Interleave ch0/ch3, then pop ch3 twice.
    for (int i = 0; i < 5; i++) begin
      cycle('0, 1'b1, 2'd0, $urandom, 1'b0, 2'd0);
      cycle('0, 1'b1, 2'd3, $urandom, 1'b0, 2'd3);
    end
    cycle('0, 1'b0, 2'd0, '0, 1'b1, 2'd3);
    cycle('0, 1'b0, 2'd0, '0, 1'b1, 2'd3);
    idle(2'd0);
    idle(2'd3);
    cycle(4'hf, 1'b0, 2'd0, '0, 1'b0, 2'd0);

    // Full ch2 with simultaneous push/pop, then drain.
    for (int i = 0; i < SZ; i++) cycle('0, 1'b1, 2'd2, $urandom, 1'b0, 2'd2);
    cycle('0, 1'b1, 2'd2, 32'hC0DE_0002, 1'b1, 2'd2);
    for (int i = 0; i < SZ; i++) cycle('0, 1'b0, 2'd0, '0, 1'b1, 2'd2);
    idle(2'd2);

    // ch0 with 3 entries: flush and write in the same cycle.
    for (int i = 0; i < 3; i++) cycle('0, 1'b1, 2'd0, $urandom, 1'b0, 2'd0);
    cycle(4'b0001, 1'b1, 2'd0, 32'hDEAD_BEEF, 1'b0, 2'd0);
    idle(2'd0);

    // Underflow on empty ch1, then flush clears the sticky error.
    cycle('0, 1'b0, 2'd0, '0, 1'b1, 2'd1);
    idle(2'd1);
    cycle(4'b0010, 1'b0, 2'd0, '0, 1'b0, 2'd1);
    idle(2'd1);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      logic [NCH-1:0] fl;
      fl = ($urandom_range(0, 15) == 0) ? NCH'($urandom) : '0;
      v = $urandom;
      cycle(fl, ($urandom_range(0, 9) < 6), 2'($urandom), v,
            ($urandom_range(0, 9) < 5), 2'($urandom));
    end

    // Reset in the middle of traffic discards everything.
    for (int i = 0; i < 4; i++) cycle('0, 1'b1, 2'(i), $urandom, 1'b0, 2'd0);
    reset_n = 1'b0;
    #2;
    chk("midreset_empty", W'(empty), W'(4'hf));
    chk("midreset_count", W'(count), '0);
    for (int c = 0; c < NCH; c++) mq[c].delete();
    merr = '0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) cycle('0, 1'b1, 2'd2, $urandom, 1'b0, 2'd2);
    for (int i = 0; i < 3; i++) cycle('0, 1'b0, 2'd0, '0, 1'b1, 2'd2);
    idle(2'd2);

    @(negedge clk); #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
